// File: rtl/jtag_pkg.sv
// Shared JTAG data-register definitions used by the word transmitter and receiver.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package jtag_pkg;

    // Default data-register length when a block is not given an explicit WIDTH.
    localparam int DR_WIDTH_DEFAULT = 32;

    // Bit-counter width able to hold 0..width. The receiver only ever reaches
    // width-1, but sharing one formula with the transmitter keeps both sides equal.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Why a partial word was discarded; the encoding is shared with the transmitter.
    typedef enum logic [1:0] {
        ABORT_NONE     = 2'd0,
        ABORT_TAP_EXIT = 2'd1,
        ABORT_RESET    = 2'd2,
        ABORT_SOFTWARE = 2'd3
    } abort_reason_t;

endpackage

// File: rtl/shift_in_counter.sv
// Serial-in shift register plus bit counter; flags the cycle in which the last bit of a word arrives.
// Latency: word_done/word are combinational in the cycle the WIDTH-th bit is presented (captured on that edge).
// Backpressure: none; bits are taken whenever enable is high, abort clears the partial word.
//
// Ports: clk/rst (async active-high), enable + in_bit (MSB first), abort,
//        word_done (completion strobe), word (completed word), bit_count (bits held).
module shift_in_counter
    import jtag_pkg::*;
#(
    parameter  int WIDTH = DR_WIDTH_DEFAULT,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             in_bit,
    input  logic             abort,
    output logic             word_done,
    output logic [WIDTH-1:0] word,
    output logic [CNT_W-1:0] bit_count
);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted   = {shift_q[WIDTH-2:0], in_bit};
        shift_d   = shift_q;
        count_d   = count_q;
        word_done = 1'b0;
        // abort outranks enable: the bit presented alongside it is discarded.
        if (abort) begin
            shift_d = '0;
            count_d = '0;
        end else if (enable) begin
            shift_d = shifted;
            if (count_q == LAST_BIT) begin
                // Wrap straight to zero so the next word can start on the following edge.
                count_d   = '0;
                word_done = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            count_q <= '0;
        end else begin
            shift_q <= shift_d;
            count_q <= count_d;
        end
    end

    // The completed word includes the bit being sampled this cycle.
    assign word      = shifted;
    assign bit_count = count_q;

endmodule

// File: rtl/word_receiver.sv
// JTAG DR serial-to-parallel receiver: collects WIDTH bits MSB first and presents them with valid/ack.
// Latency: data_out/data_valid update on the edge that samples the last bit (visible the next cycle).
// Backpressure: a word completing while data_valid is unacknowledged is dropped and sets sticky overrun.
//
// Ports: clk, reset (async active-high), enable, in_bit, abort, data_ack,
//        data_out, data_valid, overrun, bit_count, busy.
module word_receiver
    import jtag_pkg::*;
#(
    parameter  int WIDTH = DR_WIDTH_DEFAULT,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_bit,
    input  logic             abort,
    input  logic             data_ack,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun,
    output logic [CNT_W-1:0] bit_count
    ,
    output logic             busy
);

    logic             word_done;
    logic [WIDTH-1:0] word;

    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             overrun_q, overrun_d;

    shift_in_counter #(
        .WIDTH (WIDTH)
    ) u_shift_in_counter (
        .clk       (clk),
        .rst       (reset),
        .enable    (enable),
        .in_bit    (in_bit),
        .abort     (abort),
        .word_done (word_done),
        .word      (word),
        .bit_count (bit_count)
    );

    logic accept;
    logic can_load;

    always_comb begin
        // An ack only counts while there is something to acknowledge.
        accept       = data_ack && data_valid_q;
        // The output register is free if empty or being emptied this very cycle.
        can_load     = !data_valid_q || data_ack;
        data_out_d   = data_out_q;
        data_valid_d = data_valid_q;
        overrun_d    = overrun_q;

        if (word_done && can_load) begin
            data_out_d   = word;
            data_valid_d = 1'b1;
        end else if (accept) begin
            data_valid_d = 1'b0;
        end

        // Dropping a word requires data_ack low, so set and clear never coincide.
        if (word_done && !can_load) begin
            overrun_d = 1'b1;
        end else if (accept) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign overrun    = overrun_q;
    assign busy       = (bit_count != '0);

    // The counter wraps at WIDTH-1, so WIDTH itself is never held.
    a_count_in_range : assert property (@(posedge clk) disable iff (reset)
        bit_count < CNT_W'(WIDTH));

    // A word arriving into an occupied, unacknowledged output must leave overrun set.
    a_drop_sets_overrun : assert property (@(posedge clk) disable iff (reset)
        (word_done && data_valid_q && !data_ack) |=> overrun_q);

endmodule

// File: tb/tb_word_receiver.sv
module tb_word_receiver;

    localparam int W  = 32;
    localparam int CW = $clog2(W + 1);

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          enable   = 1'b0;
    logic          in_bit   = 1'b0;
    logic          abort    = 1'b0;
    logic          data_ack = 1'b0;
    logic [W-1:0]  data_out;
    logic          data_valid;
    logic          overrun;
    logic [CW-1:0] bit_count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    word_receiver #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in_bit     (in_bit),
        .abort      (abort),
        .data_ack   (data_ack),
        .data_out   (data_out),
        .data_valid (data_valid),
        .overrun    (overrun),
        .bit_count  (bit_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of bits received so far in the current word, and
    // a one-deep mailbox with a sticky lost-word flag.
    bit          m_bits[$];
    logic [W-1:0] m_out;
    bit          m_vld;
    bit          m_ovr;

    always @(posedge clk or posedge reset) begin
        bit           done;
        logic [W-1:0] w;
        if (reset) begin
            m_bits.delete();
            m_out = '0;
            m_vld = 0;
            m_ovr = 0;
        end else begin
            done = 0;
            w    = '0;
            if (abort) begin
                m_bits.delete();
            end else if (enable) begin
                m_bits.push_back(in_bit);
                if (m_bits.size() == W) begin
                    // First bit received is the MSB.
                    for (int i = 0; i < W; i++) w[W-1-i] = m_bits[i];
                    m_bits.delete();
                    done = 1;
                end
            end
            if (done && m_vld && !data_ack) begin
                m_ovr = 1;                  // mailbox full, word lost
            end else if (done) begin
                m_out = w;                  // empty or emptied this cycle
                if (data_ack && m_vld) m_ovr = 0;
                m_vld = 1;
            end else if (data_ack && m_vld) begin
                m_vld = 0;
                m_ovr = 0;
            end
        end
    end

    // Compare DUT against the model every cycle, away from the rising edge.
    always @(negedge clk) begin
        chk("cmp_data_out",   64'(data_out),   64'(m_out));
        chk("cmp_data_valid", 64'(data_valid), 64'(m_vld));
        chk("cmp_overrun",    64'(overrun),    64'(m_ovr));
        chk("cmp_bit_count",  64'(bit_count),  64'(m_bits.size()));
        chk("cmp_busy",       64'(busy),       64'(m_bits.size() != 0));
    end

    // Apply one cycle of inputs; returns 2 time units after the edge that samples them.
    task automatic step(input logic en, input logic b, input logic ab, input logic ack);
        enable   = en;
        in_bit   = b;
        abort    = ab;
        data_ack = ack;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Send one word MSB first; ack_last raises data_ack on the cycle of the final bit.
    task automatic send_word(input logic [W-1:0] w, input logic ack_last);
        for (int i = W - 1; i >= 0; i--)
            step(1'b1, w[i], 1'b0, (i == 0) ? ack_last : 1'b0);
        enable   = 1'b0;
        data_ack = 1'b0;
    endtask

    initial begin
        logic [W-1:0] w;

        // ---- reset ----
        #1 reset = 1'b1;
        #2;
        chk("rst_data_out",   64'(data_out),   64'h0);
        chk("rst_data_valid", 64'(data_valid), 64'h0);
        chk("rst_overrun",    64'(overrun),    64'h0);
        chk("rst_bit_count",  64'(bit_count),  64'h0);
        chk("rst_busy",       64'(busy),       64'h0);
        #9 reset = 1'b0;
        @(posedge clk);
        #2;

        // ---- plain word, then ack ----
        send_word(32'hDEADBEEF, 1'b0);
        chk("w1_data_out",   64'(data_out),   64'hDEADBEEF);
        chk("w1_data_valid", 64'(data_valid), 64'h1);
        chk("w1_bit_count",  64'(bit_count),  64'h0);
        chk("w1_overrun",    64'(overrun),    64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("w1_ack_valid",  64'(data_valid), 64'h0);
        // Ack with nothing pending must be ignored.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("stray_ack_valid", 64'(data_valid), 64'h0);

        // ---- enable toggling every cycle ----
        w = 32'h12345678;
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, w[i], 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == W - 3) chk("gap_bit_count", 64'(bit_count), 64'd3);
        end
        chk("gap_data_out",   64'(data_out),   64'h12345678);
        chk("gap_data_valid", 64'(data_valid), 64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // ---- aborted prefix ----
        for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("pre_abort_count", 64'(bit_count), 64'd16);
        step(1'b1, 1'b1, 1'b1, 1'b0);       // abort beats enable
        chk("abort_count", 64'(bit_count),  64'd0);
        chk("abort_busy",  64'(busy),       64'h0);
        chk("abort_valid", 64'(data_valid), 64'h0);
        send_word(32'h0000A5A5, 1'b0);
        chk("abort_data_out", 64'(data_out), 64'h0000A5A5);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // ---- overrun: second word arrives unacked ----
        send_word(32'hAAAAAAAA, 1'b0);
        send_word(32'h55555555, 1'b0);
        chk("ovr_data_out", 64'(data_out),   64'hAAAAAAAA);
        chk("ovr_overrun",  64'(overrun),    64'h1);
        chk("ovr_valid",    64'(data_valid), 64'h1);
        idle();
        chk("ovr_sticky",   64'(overrun),    64'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ovr_ack_valid",   64'(data_valid), 64'h0);
        chk("ovr_ack_overrun", 64'(overrun),    64'h0);

        // ---- completion on the same cycle as ack ----
        send_word(32'hAAAAAAAA, 1'b0);
        send_word(32'h55555555, 1'b1);
        chk("same_data_out", 64'(data_out),   64'h55555555);
        chk("same_valid",    64'(data_valid), 64'h1);
        chk("same_overrun",  64'(overrun),    64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // ---- asynchronous reset mid-word with pending word and overrun ----
        send_word(32'hAAAAAAAA, 1'b0);
        send_word(32'h55555555, 1'b0);
        w = 32'hCAFEF00D;
        for (int i = W - 1; i >= W - 20; i--) step(1'b1, w[i], 1'b0, 1'b0);
        enable = 1'b0;
        chk("pre_rst_count",   64'(bit_count),  64'd20);
        chk("pre_rst_overrun", 64'(overrun),    64'h1);
        #1 reset = 1'b1;
        #1;
        chk("arst_data_out",   64'(data_out),   64'h0);
        chk("arst_data_valid", 64'(data_valid), 64'h0);
        chk("arst_overrun",    64'(overrun),    64'h0);
        chk("arst_bit_count",  64'(bit_count),  64'h0);
        chk("arst_busy",       64'(busy),       64'h0);
        #2 reset = 1'b0;
        @(posedge clk);
        #2;
        send_word(32'hCAFEF00D, 1'b0);
        chk("post_rst_data_out", 64'(data_out),   64'hCAFEF00D);
        chk("post_rst_valid",    64'(data_valid), 64'h1);
        chk("post_rst_overrun",  64'(overrun),    64'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/word_receiver.md
Name: word_receiver

Overview:
- Serial-to-parallel counterpart of the team's word transmitter: collects WIDTH bits, MSB first, one bit per enabled clock, into a parallel word.
- Sits on the JTAG data-register path: TDI-side bits in Shift-DR are captured, then handed to core logic via a valid/ack handshake.
- Tracks bit position, supports mid-word abort (TAP leaving Shift-DR) and flags overrun when the consumer is slow.

Parameters:
- WIDTH, 32, word length in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  sample in_bit this cycle (Shift-DR active).
- in_bit  input  1  serial data, MSB of word first.
- abort  input  1  discard any partially received word.
- data_ack  input  1  consumer accepts data_out this cycle.
- data_out  output  WIDTH  last completed word, registered.
- data_valid  output  1  data_out holds an unconsumed word.
- overrun  output  1  sticky: a completed word was dropped.
- bit_count  output  CNT_W  bits collected in current partial word (0..WIDTH-1).
- busy  output  1  bit_count != 0.

Behaviour:
- Reset (async assert, sync release): shift_reg=0, bit_count=0, data_out=0, data_valid=0, overrun=0, busy=0.
- Shift: on clk edge with enable=1 and abort=0, shift_reg <= {shift_reg[WIDTH-2:0], in_bit}; bit_count <= bit_count+1.
- Completion: the edge that samples the WIDTH-th bit (bit_count==WIDTH-1 and enable) sets bit_count to 0. The completed word is {shift_reg[WIDTH-2:0], in_bit}.
- Completion latency: data_out and data_valid update on that same edge. They are visible in the cycle after the last bit is sampled.
- Back-to-back words need no gap cycle; bit 0 of the next word may be sampled on the edge after completion.
- Handshake:
  - data_valid stays high until a cycle with data_ack=1; it clears on that edge.
  - data_ack while data_valid=0 is ignored.
- Completion while data_valid=1 and data_ack=0:
  - the new word is dropped;
  - data_out keeps the old word;
  - overrun <= 1.
- Completion and data_ack=1 in the same cycle: the new word loads, data_valid stays 1, no overrun.
- overrun is sticky. It clears only on the first data_ack accepted after it was set, or on reset.
- abort:
  - sets bit_count <= 0 and shift_reg <= 0;
  - does not touch data_out, data_valid or overrun;
  - wins over enable in the same cycle, so the bit is discarded and no completion occurs;
  - abort with data_ack in the same cycle: both take effect.
- enable=0: shift_reg and bit_count hold. Gaps of any length inside a word are legal.
- Reset mid-word or mid-handshake: all state is lost immediately; the partial word is not reported.
- bit_count never reaches WIDTH. busy is combinational from bit_count.
- No X propagation: data_out is never driven from an unwritten register; assertions check this in formal.
- Formal properties:
  - bit_count < WIDTH always;
  - data_valid rises only on a completion edge;
  - a completion while valid without ack implies overrun next cycle;
  - after reset with no abort, the number of enabled cycles equals completions*WIDTH + bit_count.

Decomposition:
- Shared package jtag_pkg holds:
  - DR_WIDTH_DEFAULT=32;
  - a function computing CNT_W;
  - the abort-reason encoding shared with the transmitter.
- One natural sub-module, shift_in_counter: shift register plus bit counter with enable/abort, producing a one-cycle word_done and word.
- word_receiver wraps shift_in_counter and adds the output register, valid/ack handshake and overrun logic.

Test Plan:
- Reset, then 32 enabled cycles shifting 0xDEADBEEF MSB first -> cycle after bit 32: data_out=0xDEADBEEF, data_valid=1, bit_count=0, overrun=0; data_ack pulse -> data_valid=0 next cycle.
- 0x12345678 sent with enable toggled 1/0 every cycle (64 clocks) -> same word captured; bit_count increments only on enabled cycles.
- 16 bits of 0xFFFF, abort, then 32 bits of 0x0000A5A5 -> data_out=0x0000A5A5; no valid asserted after the aborted prefix.
- Word 0xAAAAAAAA left unacked, second word 0x55555555 completes with data_ack=0 -> data_out stays 0xAAAAAAAA, overrun=1; next data_ack clears both data_valid and overrun.
- Second word 0x55555555 completes on the exact cycle data_ack=1 for 0xAAAAAAAA -> data_out=0x55555555, data_valid stays 1, overrun=0.
- Reset asserted asynchronously mid-clock at bit 20 with data_valid=1 -> all outputs 0 immediately, before the next clk edge; subsequent full word 0xCAFEF00D captured correctly.
